mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one SRAM-like memory port between the CPU's instruction-fetch requester and its load/store requester. Sits between the pipeline's instruction and data memory interfaces and the single downstream memory/bus bridge. Applies the kseg0/kseg1 physical address mapping, arbitrates, and sequences exactly one outstanding transaction through address and data phases.

## Interface
Parameters:
- ARB_MODE, 0: 0 = fixed data-over-instruction priority; 1 = round-robin.
- MAP_KSEG, 1: 1 = map kseg0/kseg1 to physical addresses; 0 = pass addresses unchanged.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous and active-high
- inst_req  in  1  instruction read request
- inst_addr  in  32  instruction virtual address
- inst_addr_ok  out  1  instruction request accepted this cycle
- inst_data_ok  out  1  instruction read data valid this cycle
- inst_rdata  out  32  instruction read data
- data_req  in  1  data request
- data_wr  in  1  1 = write, 0 = read
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_addr  in  32  data virtual address
- data_wdata  in  32  write data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  data read data valid or write complete this cycle
- data_rdata  out  32  data read data
- mem_req  out  1  downstream request
- mem_wr  out  1  downstream write flag
- mem_size  out  2  downstream size
- mem_addr  out  32  downstream physical address
- mem_wdata  out  32  downstream write data
- mem_addr_ok  in  1  downstream accepted address
- mem_data_ok  in  1  downstream response
- mem_rdata  in  32  downstream read data
- busy  out  1  transaction in flight (state != IDLE)

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE: if any request is present, grant one and pulse its *_addr_ok combinationally in the same cycle. Latch owner, wr, size, mapped addr and wdata into registers, then go to REQ. Instruction grants latch wr=0, size=2, wdata=0.
- Grant, ARB_MODE=0: data_req wins whenever asserted.
- Grant, ARB_MODE=1: if both requesters are asserting, grant the one not granted last. A single requester always wins. last_owner updates on each grant.
- REQ: mem_req=1 with the latched fields, held stable until mem_addr_ok. On mem_addr_ok go to WAIT. If mem_data_ok is also high in that cycle, complete directly (same as WAIT completion).
- WAIT: mem_req=0. On mem_data_ok, forward a one-cycle *_data_ok to the owner, go to IDLE.
- Response routing: the owner's *_rdata = mem_rdata. The other requester's rdata is 0 and its data_ok is 0. Writes also return data_ok.
- mem_data_ok is ignored in IDLE. A stray response never produces a data_ok.
- Address map (MAP_KSEG=1): if addr[31:30]==2'b10, physical = {3'b000, addr[28:0]}; otherwise unchanged.
- Address map (MAP_KSEG=0): addresses pass through unchanged.
- Reset mid-operation abandons the transaction. Late downstream responses are dropped.

## Timing
- Reset values:
  - state IDLE, last_owner = inst.
  - mem_req/mem_wr 0, mem_size 0, mem_addr 0, mem_wdata 0.
  - All *_addr_ok/*_data_ok 0, busy 0, inst_rdata/data_rdata 0.
- Accept cycle: *_addr_ok is asserted in cycle N (IDLE, request present). mem_req is first asserted in cycle N+1.
- mem_* outputs are registered. *_addr_ok, *_data_ok and *_rdata are combinational from state and downstream inputs.
- Minimum transaction (mem_addr_ok in N+1, mem_data_ok in N+2): data_ok in N+2, next accept no earlier than N+3 (one IDLE bubble).
- Only one outstanding transaction at a time. Neither *_addr_ok is asserted outside IDLE.

## Structure
- Package cpu_mem_pkg holds:
  - the state enum (IDLE/REQ/WAIT);
  - the owner enum (OWN_INST/OWN_DATA);
  - the size constants SZ_BYTE/SZ_HALF/SZ_WORD;
  - the function kseg_map(addr).
- One combinational sub-module, mem_addr_map, wraps kseg_map with the MAP_KSEG parameter. The arbiter instantiates it on the selected request address before latching.

## Test plan
- Single instruction read, addr 0xbfc0_0000:
  - inst_addr_ok in cycle 0;
  - mem_addr = 0x1fc0_0000, mem_req in cycle 1;
  - mem_rdata 0x2408_0001 with mem_data_ok in cycle 3 gives inst_data_ok and inst_rdata 0x2408_0001 in cycle 3.
- Data write, addr 0xbfaf_f000, wdata 0x0000_00ff, size 2: mem_wr=1, mem_addr 0x1faf_f000; data_data_ok on the response; inst outputs stay 0.
- Simultaneous inst_req and data_req held:
  - ARB_MODE=0: data granted on every accept, inst starves.
  - ARB_MODE=1: grants alternate D, I, D, I, first grant data.
- mem_addr_ok and mem_data_ok in the same REQ cycle: data_ok fires that cycle, FSM returns to IDLE, busy drops next cycle.
- Address mapping boundaries:
  - 0x8000_0100 maps to 0x0000_0100;
  - 0xc000_0000 and 0x1fc0_0000 are unchanged;
  - with MAP_KSEG=0, 0xbfaf_0000 is unchanged.
- Reset robustness:
  - rst asserted in WAIT: all outputs go to reset values immediately (async);
  - mem_data_ok after reset release produces no data_ok;
  - a fresh request is then accepted normally.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types and helpers for the CPU memory-port arbiter.
// State/owner enums, access sizes and the kseg0/kseg1 address map.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    typedef enum logic {
        OWN_INST,
        OWN_DATA
    } owner_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // kseg0 (0x8...) and kseg1 (0xa...) both fold onto the low 512 MB
    function automatic logic [31:0] kseg_map(input logic [31:0] addr);
        logic [31:0] phys;
        phys = addr;
        if (addr[31:30] == 2'b10) begin
            phys = {3'b000, addr[28:0]};
        end
        return phys;
    endfunction

endpackage

// File: rtl/mem_addr_map.sv
// Virtual-to-physical address translation for the shared memory port.
// With MAP_KSEG=0 addresses pass through untouched.
module mem_addr_map
    import cpu_mem_pkg::*;
#(
    parameter bit MAP_KSEG = 1'b1
) (
    input  logic [31:0] vaddr,
    output logic [31:0] paddr
);

    assign paddr = MAP_KSEG ? kseg_map(vaddr) : vaddr;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction and data requesters onto one SRAM-like port,
// keeping a single transaction in flight through address and data phases.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ARB_MODE = 0,
    parameter bit MAP_KSEG = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    state_t      state;
    state_t      state_nxt;
    owner_t      owner;
    owner_t      last_owner;
    logic        grant_data;
    logic        grant_inst;
    logic        done;
    logic [31:0] sel_vaddr;
    logic [31:0] sel_paddr;

    assign sel_vaddr = grant_data ? data_addr : inst_addr;

    mem_addr_map #(
        .MAP_KSEG(MAP_KSEG)
    ) u_map (
        .vaddr(sel_vaddr),
        .paddr(sel_paddr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Round-robin only matters when both requesters collide
    always_comb begin
        state_nxt  = state;
        grant_data = 1'b0;
        grant_inst = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rst && data_req &&
                    (ARB_MODE == 0 || !inst_req ||
                     last_owner == OWN_INST)) begin
                    grant_data = 1'b1;
                end else if (!rst && inst_req) begin
                    grant_inst = 1'b1;
                end
                if (grant_data || grant_inst) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem_addr_ok) begin
                    done      = mem_data_ok;
                    state_nxt = mem_data_ok ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (mem_data_ok) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= OWN_INST;
            last_owner <= OWN_INST;
            mem_req    <= 1'b0;
            mem_wr     <= 1'b0;
            mem_size   <= SZ_BYTE;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else if (grant_data || grant_inst) begin
            owner      <= grant_data ? OWN_DATA : OWN_INST;
            last_owner <= grant_data ? OWN_DATA : OWN_INST;
            mem_req    <= 1'b1;
            mem_wr     <= grant_data & data_wr;
            mem_size   <= grant_data ? data_size : SZ_WORD;
            mem_addr   <= sel_paddr;
            mem_wdata  <= grant_data ? data_wdata : '0;
        end else if (state == REQ && mem_addr_ok) begin
            mem_req <= 1'b0;
        end
    end

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign inst_data_ok = done && owner == OWN_INST;
    assign data_data_ok = done && owner == OWN_DATA;
    assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
    assign data_rdata   = data_data_ok ? mem_rdata : '0;
    assign busy         = state != IDLE;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model compared every cycle
// on two configurations, plus directed literal expectations.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [1:0]  data_size = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        mem_addr_ok = 1'b0;
    logic        mem_data_ok = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        o_iaok [2];
    logic        o_idok [2];
    logic [31:0] o_irdata [2];
    logic        o_daok [2];
    logic        o_ddok [2];
    logic [31:0] o_drdata [2];
    logic        o_mreq [2];
    logic        o_mwr [2];
    logic [1:0]  o_msz [2];
    logic [31:0] o_maddr [2];
    logic [31:0] o_mwd [2];
    logic        o_busy [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // u0: fixed priority, kseg mapped; u1: round-robin, no mapping
    mem_port_arbiter #(.ARB_MODE(0), .MAP_KSEG(1'b1)) u0 (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(o_iaok[0]), .inst_data_ok(o_idok[0]),
        .inst_rdata(o_irdata[0]),
        .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata),
        .data_addr_ok(o_daok[0]), .data_data_ok(o_ddok[0]),
        .data_rdata(o_drdata[0]),
        .mem_req(o_mreq[0]), .mem_wr(o_mwr[0]),
        .mem_size(o_msz[0]), .mem_addr(o_maddr[0]),
        .mem_wdata(o_mwd[0]),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata), .busy(o_busy[0])
    );

    mem_port_arbiter #(.ARB_MODE(1), .MAP_KSEG(1'b0)) u1 (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(o_iaok[1]), .inst_data_ok(o_idok[1]),
        .inst_rdata(o_irdata[1]),
        .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata),
        .data_addr_ok(o_daok[1]), .data_data_ok(o_ddok[1]),
        .data_rdata(o_drdata[1]),
        .mem_req(o_mreq[1]), .mem_wr(o_mwr[1]),
        .mem_size(o_msz[1]), .mem_addr(o_maddr[1]),
        .mem_wdata(o_mwd[1]),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata), .busy(o_busy[1])
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int          arb [2] = '{0, 1};
    bit          mapk [2] = '{1'b1, 1'b0};
    int          ph [2] = '{0, 0};
    bit          own [2] = '{0, 0};
    bit          last [2] = '{0, 0};
    logic        mwr [2] = '{0, 0};
    logic [1:0]  msz [2] = '{0, 0};
    logic [31:0] maddr [2] = '{0, 0};
    logic [31:0] mwd [2] = '{0, 0};

    function automatic logic [31:0] phys(int k, logic [31:0] a);
        if (mapk[k] && a >= 32'h8000_0000 && a < 32'hc000_0000)
            return a & 32'h1fff_ffff;
        return a;
    endfunction

    function automatic bit gd(int k);
        return !rst && ph[k] == 0 && data_req &&
               (arb[k] == 0 || !inst_req || last[k] == 1'b0);
    endfunction

    function automatic bit gi(int k);
        return !rst && ph[k] == 0 && inst_req && !gd(k);
    endfunction

    function automatic bit dn(int k);
        return (ph[k] == 1 && mem_addr_ok && mem_data_ok) ||
               (ph[k] == 2 && mem_data_ok);
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                ph[k] = 0; own[k] = 0; last[k] = 0;
                mwr[k] = 0; msz[k] = 0; maddr[k] = 0; mwd[k] = 0;
            end else begin
                bit g_d;
                bit g_i;
                g_d = gd(k);
                g_i = gi(k);
                if (ph[k] == 0) begin
                    if (g_d) begin
                        own[k] = 1; last[k] = 1; ph[k] = 1;
                        mwr[k] = data_wr; msz[k] = data_size;
                        maddr[k] = phys(k, data_addr);
                        mwd[k] = data_wdata;
                    end else if (g_i) begin
                        own[k] = 0; last[k] = 0; ph[k] = 1;
                        mwr[k] = 0; msz[k] = 2;
                        maddr[k] = phys(k, inst_addr);
                        mwd[k] = 0;
                    end
                end else if (ph[k] == 1) begin
                    if (mem_addr_ok) ph[k] = mem_data_ok ? 0 : 2;
                end else if (mem_data_ok) begin
                    ph[k] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit d;
            d = dn(k);
            chk($sformatf("u%0d.inst_addr_ok", k), o_iaok[k], gi(k));
            chk($sformatf("u%0d.data_addr_ok", k), o_daok[k], gd(k));
            chk($sformatf("u%0d.inst_data_ok", k), o_idok[k],
                d && !own[k]);
            chk($sformatf("u%0d.data_data_ok", k), o_ddok[k],
                d && own[k]);
            chk($sformatf("u%0d.inst_rdata", k), o_irdata[k],
                (d && !own[k]) ? mem_rdata : 0);
            chk($sformatf("u%0d.data_rdata", k), o_drdata[k],
                (d && own[k]) ? mem_rdata : 0);
            chk($sformatf("u%0d.mem_req", k), o_mreq[k], ph[k] == 1);
            chk($sformatf("u%0d.mem_wr", k), o_mwr[k], mwr[k]);
            chk($sformatf("u%0d.mem_size", k), o_msz[k], msz[k]);
            chk($sformatf("u%0d.mem_addr", k), o_maddr[k], maddr[k]);
            chk($sformatf("u%0d.mem_wdata", k), o_mwd[k], mwd[k]);
            chk($sformatf("u%0d.busy", k), o_busy[k], ph[k] != 0);
        end
    end

    // ---------------- directed stimulus ----------------
    logic        s_aok;
    logic        s_dok;
    logic        s_odok;
    logic [31:0] s_rd;
    logic [31:0] s_ord;
    logic [31:0] s_ma0;
    logic [31:0] s_ma1;
    logic        s_wr;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input bit isd, input bit wr,
                       input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd,
                       input bit fast, input int lat);
        tick;
        if (isd) begin
            data_req = 1; data_wr = wr; data_size = sz;
            data_addr = a; data_wdata = wd;
        end else begin
            inst_req = 1; inst_addr = a;
        end
        @(negedge clk);
        s_aok = isd ? o_daok[0] : o_iaok[0];
        tick;
        inst_req = 0; data_req = 0;
        mem_addr_ok = 1; mem_data_ok = fast; mem_rdata = fast ? rd : 0;
        @(negedge clk);
        s_ma0 = o_maddr[0]; s_ma1 = o_maddr[1]; s_wr = o_mwr[0];
        if (!fast) begin
            tick;
            mem_addr_ok = 0;
            for (int i = 0; i < lat; i++) tick;
            mem_data_ok = 1; mem_rdata = rd;
            @(negedge clk);
        end
        s_dok  = isd ? o_ddok[0] : o_idok[0];
        s_odok = isd ? o_idok[0] : o_ddok[0];
        s_rd   = isd ? o_drdata[0] : o_irdata[0];
        s_ord  = isd ? o_irdata[0] : o_drdata[0];
        tick;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    endtask

    initial begin
        tick; tick;
        rst = 0;
        @(negedge clk);
        chk("reset_mem_req", o_mreq[0], 0);
        chk("reset_mem_addr", o_maddr[0], 0);
        chk("reset_busy", o_busy[0], 0);

        txn(0, 0, 2, 32'hbfc0_0000, 0, 32'h2408_0001, 0, 1);
        chk("t1_inst_addr_ok", s_aok, 1);
        chk("t1_mem_addr", s_ma0, 32'h1fc0_0000);
        chk("t1_mem_addr_nomap", s_ma1, 32'hbfc0_0000);
        chk("t1_inst_data_ok", s_dok, 1);
        chk("t1_inst_rdata", s_rd, 32'h2408_0001);

        txn(1, 1, 2, 32'hbfaf_f000, 32'h0000_00ff, 0, 0, 0);
        chk("t2_data_addr_ok", s_aok, 1);
        chk("t2_mem_wr", s_wr, 1);
        chk("t2_mem_addr", s_ma0, 32'h1faf_f000);
        chk("t2_data_data_ok", s_dok, 1);
        chk("t2_inst_data_ok", s_odok, 0);
        chk("t2_inst_rdata", s_ord, 0);

        txn(1, 0, 1, 32'h8000_0100, 0, 32'h1234_5678, 1, 0);
        chk("t3_map_kseg0", s_ma0, 32'h0000_0100);
        chk("t3_fast_data_ok", s_dok, 1);
        chk("t3_fast_rdata", s_rd, 32'h1234_5678);
        @(negedge clk);
        chk("t3_busy_after", o_busy[0], 0);

        txn(1, 0, 0, 32'hc000_0000, 0, 0, 0, 0);
        chk("map_kseg2", s_ma0, 32'hc000_0000);
        txn(1, 0, 0, 32'h1fc0_0000, 0, 0, 0, 0);
        chk("map_kuseg", s_ma0, 32'h1fc0_0000);
        txn(1, 0, 2, 32'hbfaf_0000, 0, 0, 0, 0);
        chk("map_off", s_ma1, 32'hbfaf_0000);
        chk("map_on", s_ma0, 32'h1faf_0000);

        tick; rst = 1;
        tick; rst = 0;
        inst_req = 1; inst_addr = 32'hbfc0_0010;
        data_req = 1; data_addr = 32'h8000_2000;
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            chk($sformatf("fixed_grant%0d", g), o_daok[0], 1);
            chk($sformatf("fixed_starve%0d", g), o_iaok[0], 0);
            chk($sformatf("rr_grant%0d", g), o_daok[1], (g % 2) == 0);
            chk($sformatf("rr_inst%0d", g), o_iaok[1], (g % 2) == 1);
            tick; mem_addr_ok = 1;
            tick; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = g;
            tick; mem_data_ok = 0; mem_rdata = 0;
        end
        inst_req = 0; data_req = 0;

        tick; inst_req = 1; inst_addr = 32'hbfc0_0004;
        tick; inst_req = 0; mem_addr_ok = 1;
        tick; mem_addr_ok = 0;
        rst = 1; mem_data_ok = 1; mem_rdata = 32'hdead_beef;
        #1;
        chk("rst_async_busy", o_busy[0], 0);
        chk("rst_async_mem_addr", o_maddr[0], 0);
        chk("rst_async_mem_size", o_msz[0], 0);
        chk("rst_async_inst_data_ok", o_idok[0], 0);
        chk("rst_async_inst_rdata", o_irdata[0], 0);
        tick; rst = 0;
        @(negedge clk);
        chk("stray_inst_data_ok", o_idok[0], 0);
        chk("stray_data_data_ok", o_ddok[0], 0);
        tick; mem_data_ok = 0; mem_rdata = 0;

        txn(0, 0, 2, 32'h9fc0_0008, 0, 32'hcafe_0001, 0, 0);
        chk("post_rst_addr_ok", s_aok, 1);
        chk("post_rst_mem_addr", s_ma0, 32'h1fc0_0008);
        chk("post_rst_data_ok", s_dok, 1);
        chk("post_rst_rdata", s_rd, 32'hcafe_0001);

        tick; tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
